// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK,
    ST_IGNORE
  } i2c_target_state_t;

  // Level seen on SDA during the acknowledge bit.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // True when the first byte after START addresses us. Address 0 is the
  // general call, which this target never answers.
  function automatic logic addr_hit(input logic [7:0] addr_byte,
                                    input logic [6:0] own_addr);
    return (addr_byte[7:1] != 7'h00) && (addr_byte[7:1] == own_addr);
  endfunction

endpackage

// File: rtl/i2c_sync.sv
// Synchronizer for one asynchronous bus pin, followed by a rise/fall
// detector. Edges are suppressed until the chain has been refilled with real
// pin samples after reset, so a bus that is low when reset is released does
// not produce a false edge.
module i2c_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [STAGES:0]   arm;

  // Synchronizer chain, edge-detect flop and post-reset arming shift register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments model the flop chain; blocking ones here
    // would collapse the stages into a single flop.
    if (rst) begin
      chain <= '1;
      prev  <= 1'b1;
      arm   <= '0;
    end else begin
      chain[0] <= pin;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev   <= chain[STAGES-1];
      arm[0] <= 1'b1;
      for (int i = 1; i <= STAGES; i++) arm[i] <= arm[i-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = arm[STAGES] &  level & ~prev;
  assign fall  = arm[STAGES] & ~level &  prev;

endmodule

// File: rtl/i2c_target.sv
// 7-bit I2C target: address match, write bytes out on wr_data/wr_valid,
// read bytes fetched through rd_req/rd_data, open-drain SDA via sda_oe.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  input  logic [7:0] rd_data,
  output logic       rd_req,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start_ev, stop_ev;

  i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (scl_i),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (sda_i),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // SDA moving while SCL is high is a bus condition, never a data bit.
  assign start_ev = sda_fall & scl;
  assign stop_ev  = sda_rise & scl;

  i2c_target_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_oe_d, busy_d, wr_valid_d, rd_req_d, start_det_d, stop_det_d;
  logic [7:0] wr_data_d;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_data   <= 8'h00;
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      wr_data   <= wr_data_d;
      wr_valid  <= wr_valid_d;
      rd_req    <= rd_req_d;
      start_det <= start_det_d;
      stop_det  <= stop_det_d;
    end
  end

  // Next-state and next-output logic; bus conditions override bit events.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe;
    busy_d      = busy;
    wr_data_d   = wr_data;
    wr_valid_d  = 1'b0;
    rd_req_d    = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;

    if (start_ev) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_ev) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = 3'd0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (addr_hit(shift_d, TARGET_ADDR)) begin
              state_d = ST_ADDR_ACK;
              rw_d    = shift_d[0];
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end

        // First falling edge starts the ACK, second one ends it. sda_oe
        // itself tells the two apart.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_d = ~I2C_ACK;
            busy_d   = 1'b1;
          end else if (rw_q) begin
            rd_req_d  = 1'b1;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = ST_READ;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = ST_WRITE;
          end
        end

        ST_WRITE: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_data_d  = shift_d;
            wr_valid_d = 1'b1;
            state_d    = ST_WRITE_ACK;
          end
        end

        ST_WRITE_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_d = ~I2C_ACK;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = ST_WRITE;
          end
        end

        // The cycle rd_req is high is the cycle rd_data is taken; bit 7
        // appears on the bus one cycle later.
        ST_READ: begin
          if (rd_req) begin
            shift_d  = rd_data;
            sda_oe_d = ~rd_data[7];
          end else if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = ST_READ_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_d[7];
            end
          end
        end

        // The controller's ACK is sampled on the rising edge; the falling
        // edge that follows an ACK fetches the next byte.
        ST_READ_ACK: begin
          if (scl_rise && (sda == I2C_NACK)) begin
            state_d = ST_IGNORE;
          end else if (scl_fall) begin
            rd_req_d  = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = ST_READ;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-banged I2C controller, a
// table of whole transactions, and hand-written corner-case sequences.
module tb_i2c_target;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_ctl = 1'b1;
  logic       sda_ctl = 1'b1;
  logic       sda_bus;
  logic [7:0] rd_data = 8'h00;
  logic       sda_oe, wr_valid, rd_req, busy, start_det, stop_det;
  logic [7:0] wr_data;

  assign sda_bus = sda_ctl & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_ctl),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .rd_data   (rd_data),
    .rd_req    (rd_req),
    .busy      (busy),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Cumulative event counters; tests take deltas around each transaction.
  int         start_cnt = 0, stop_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  int         oe_cyc = 0, busy_cyc = 0;
  logic [7:0] wr_log [64];

  always @(negedge clk) begin
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
    if (rd_req) rd_cnt++;
    if (sda_oe) oe_cyc++;
    if (busy) busy_cyc++;
    if (wr_valid) begin
      wr_log[wr_cnt % 64] = wr_data;
      wr_cnt++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Bit-banged controller.
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_ctl = 1'b1; wait_q();
    scl_ctl = 1'b1; wait_q();
    sda_ctl = 1'b0; wait_q();
    scl_ctl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_ctl = 1'b0; wait_q();
    scl_ctl = 1'b1; wait_q();
    sda_ctl = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    sda_ctl = b;    wait_q();
    scl_ctl = 1'b1; wait_q(); wait_q();
    scl_ctl = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    sda_ctl = 1'b1; wait_q();
    scl_ctl = 1'b1; wait_q();
    b = sda_bus;    wait_q();
    scl_ctl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
  endtask

  typedef struct {
    logic [7:0]  addr_byte;   // address + R/W
    int          nbytes;      // data bytes (1 or 2)
    logic [15:0] data;        // write bytes, or rd_data bytes; first in [15:8]
    logic        exp_ack;     // target acknowledges the address
    int          exp_wr;      // expected wr_valid pulses
    logic [15:0] exp_wr_data; // expected wr_data bytes, first in [15:8]
    int          exp_rd;      // expected rd_req pulses
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic       ack, b;
    logic [7:0] byt, exp_byte;
    int         s0, p0, w0, r0, o0, b0;

    vecs[0] = '{8'h84, 2, 16'hA53C, 1'b1, 2, 16'hA53C, 0};  // write A5,3C
    vecs[1] = '{8'h86, 1, 16'h5500, 1'b0, 0, 16'h0000, 0};  // wrong address
    vecs[2] = '{8'h85, 2, 16'h5AC3, 1'b1, 0, 16'h0000, 2};  // read 5A,C3
    vecs[3] = '{8'h00, 1, 16'h1200, 1'b0, 0, 16'h0000, 0};  // general call
    vecs[4] = '{8'h84, 2, 16'hFF00, 1'b1, 2, 16'hFF00, 0};  // all-ones/all-zeros
    vecs[5] = '{8'h85, 1, 16'h8100, 1'b1, 0, 16'h0000, 1};  // single read, NACK

    // Reset state.
    repeat (5) @(negedge clk);
    check("reset_outputs", {sda_oe, busy, wr_valid, rd_req, start_det, stop_det, wr_data}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_no_start", start_cnt, 0);

    // Table of complete transactions.
    for (int i = 0; i < NV; i++) begin
      v  = vecs[i];
      s0 = start_cnt; p0 = stop_cnt; w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cyc; b0 = busy_cyc;
      rd_data = v.data[15:8];
      i2c_start();
      send_byte(v.addr_byte, ack);
      check($sformatf("v%0d_addr_ack", i), ack, !v.exp_ack);
      for (int j = 0; j < v.nbytes; j++) begin
        exp_byte = (j == 0) ? v.data[15:8] : v.data[7:0];
        if (v.addr_byte[0]) begin
          recv_byte(byt);
          check($sformatf("v%0d_rd_byte%0d", i, j), byt, exp_byte);
          if (j < v.nbytes - 1) begin
            rd_data = v.data[7:0];
            send_bit(1'b0);
          end else begin
            send_bit(1'b1);
          end
        end else begin
          send_byte(exp_byte, ack);
          check($sformatf("v%0d_data_ack%0d", i, j), ack, !v.exp_ack);
        end
      end
      i2c_stop();
      repeat (5) @(negedge clk);
      check($sformatf("v%0d_start_cnt", i), start_cnt - s0, 1);
      check($sformatf("v%0d_stop_cnt", i), stop_cnt - p0, 1);
      check($sformatf("v%0d_wr_cnt", i), wr_cnt - w0, v.exp_wr);
      for (int k = 0; k < v.exp_wr; k++)
        check($sformatf("v%0d_wr_data%0d", i, k), wr_log[(w0 + k) % 64],
              (k == 0) ? v.exp_wr_data[15:8] : v.exp_wr_data[7:0]);
      check($sformatf("v%0d_rd_cnt", i), rd_cnt - r0, v.exp_rd);
      check($sformatf("v%0d_oe_used", i), oe_cyc != o0, v.exp_ack);
      check($sformatf("v%0d_busy_seen", i), busy_cyc != b0, v.exp_ack);
      check($sformatf("v%0d_idle_after_stop", i), {sda_oe, busy}, 2'b00);
    end

    // Write 0x11, repeated START, read one byte with NACK.
    s0 = start_cnt; p0 = stop_cnt; w0 = wr_cnt; r0 = rd_cnt;
    i2c_start();
    send_byte(8'h84, ack);  check("rs_addr_w_ack", ack, 1'b0);
    send_byte(8'h11, ack);  check("rs_data_ack", ack, 1'b0);
    rd_data = 8'h96;
    i2c_start();
    send_byte(8'h85, ack);  check("rs_addr_r_ack", ack, 1'b0);
    recv_byte(byt);         check("rs_rd_byte", byt, 8'h96);
    send_bit(1'b1);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("rs_wr_cnt", wr_cnt - w0, 1);
    check("rs_wr_data", wr_log[w0 % 64], 8'h11);
    check("rs_start_cnt", start_cnt - s0, 2);
    check("rs_rd_cnt", rd_cnt - r0, 1);
    check("rs_stop_cnt", stop_cnt - p0, 1);

    // Reset pulse while SCL is high during data bit 4 (SDA low).
    i2c_start();
    send_byte(8'h84, ack);  check("mr_addr_ack", ack, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    sda_ctl = 1'b0; wait_q();
    scl_ctl = 1'b1; wait_q();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("mr_reset_outputs", {sda_oe, busy, wr_valid, rd_req, wr_data}, 12'h000);
    s0 = start_cnt; w0 = wr_cnt; o0 = oe_cyc;
    wait_q();
    scl_ctl = 1'b0; wait_q();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    recv_bit(ack);          check("mr_no_ack_after_reset", ack, 1'b1);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("mr_no_false_start", start_cnt - s0, 0);
    check("mr_no_wr", wr_cnt - w0, 0);
    check("mr_no_oe", oe_cyc - o0, 0);
    w0 = wr_cnt;
    i2c_start();
    send_byte(8'h84, ack);  check("mr_next_addr_ack", ack, 1'b0);
    send_byte(8'h77, ack);  check("mr_next_data_ack", ack, 1'b0);
    i2c_stop();
    repeat (5) @(negedge clk);
    check("mr_next_wr_data", (wr_cnt - w0 == 1) ? wr_log[w0 % 64] : 8'hxx, 8'h77);

    // STOP in the middle of a read byte (0x5A: bit 6 is 1, so SDA is free).
    r0 = rd_cnt; p0 = stop_cnt;
    rd_data = 8'h5A;
    i2c_start();
    send_byte(8'h85, ack);  check("ms_addr_ack", ack, 1'b0);
    recv_bit(b);            check("ms_bit7", b, 1'b0);
    sda_ctl = 1'b0; wait_q();
    scl_ctl = 1'b1; wait_q();
    sda_ctl = 1'b1;
    repeat (5) @(negedge clk);
    check("ms_stop_seen", stop_cnt - p0, 1);
    check("ms_released", {sda_oe, busy}, 2'b00);
    o0 = oe_cyc;
    wait_q();
    scl_ctl = 1'b0; wait_q();
    for (int i = 0; i < 8; i++) recv_bit(b);
    check("ms_no_more_rd_req", rd_cnt - r0, 1);
    check("ms_no_oe_after_stop", oe_cyc - o0, 0);
    i2c_start();
    i2c_stop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter: TARGET_ADDR, default 7'h42, 7-bit address this target answers to.
REQ-002 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on scl_i/sda_i.
REQ-003 clk  input  1  single system clock, all logic on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 scl_i  input  1  raw SCL pin level, asynchronous.
REQ-006 sda_i  input  1  raw SDA pin level, asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low, 0 = release (open drain); registered.
REQ-008 wr_data  output  8  last byte received from the controller.
REQ-009 wr_valid  output  1  one-cycle pulse, wr_data valid.
REQ-010 rd_data  input  8  byte to send; must be stable in the cycle rd_req is high.
REQ-011 rd_req  output  1  one-cycle pulse, target captures rd_data this cycle.
REQ-012 busy  output  1  high from a matching address ACK until STOP, START or reset.
REQ-013 start_det, stop_det  output  1 each  one-cycle pulses on detected START/STOP.

Function
REQ-014 scl_i/sda_i SHALL pass SYNC_STAGES flops plus one edge-detect flop; internal events lag pins by SYNC_STAGES+1 cycles.
REQ-015 clk SHALL be at least 20x the SCL frequency; slower clk is unsupported.
REQ-016 START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; both take priority over data events in the same cycle.
REQ-017 States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
REQ-018 START (incl. repeated) in any state -> ADDR, bit counter cleared, sda_oe=0 next cycle.
REQ-019 STOP in any state -> IDLE, sda_oe=0, busy=0 next cycle.
REQ-020 Data bits SHALL be sampled MSB first on SCL rising; sda_oe SHALL change only on SCL falling.
REQ-021 ADDR: after 8th bit, address[7:1]==TARGET_ADDR -> ADDR_ACK; mismatch -> IGNORE (sda_oe stays 0 until START/STOP).
REQ-022 ADDR_ACK: sda_oe=1 from next SCL falling to the following SCL falling; busy asserts with sda_oe.
REQ-023 R/W=0 -> WRITE; each 8th rising edge SHALL update wr_data and pulse wr_valid same cycle, then WRITE_ACK (always ACK, no backpressure).
REQ-024 R/W=1 -> at SCL falling ending ACK, rd_req pulses, rd_data captured same cycle, sda_oe=~bit7 next cycle -> READ.
REQ-025 READ: each SCL falling shifts next bit; after bit 0's falling, sda_oe=0 -> READ_ACK.
REQ-026 READ_ACK: controller ACK (SDA=0 at rising) -> next falling repeats REQ-024; NACK -> IGNORE.
REQ-027 Bit counter 0..7 SHALL wrap to 0 on entering any ACK state; never overflows.
REQ-028 General call (address 0) SHALL be treated as mismatch.

Reset
REQ-029 rst SHALL force IDLE, sda_oe=0, wr_valid=0, rd_req=0, busy=0, start_det=0, stop_det=0, wr_data=8'h00, counters and synchronizers to 1 (idle bus) within one cycle, including mid-transfer.
REQ-030 After rst release, a transfer already in progress SHALL be ignored until the next START.

Structure
REQ-031 State enum i2c_target_state_t and constants (I2C_ACK=0, I2C_NACK=1) SHALL live in shared package i2c_pkg.
REQ-032 One sub-module i2c_sync (synchronizer + rise/fall detect) SHALL be instantiated twice, once each for SCL and SDA.
REQ-033 All outputs registered; no combinational path from scl_i/sda_i to sda_oe.

Verification
REQ-034 Write 0x84 (addr 0x42 W), data 0xA5, 0x3C, STOP -> ACKs on all 3 bytes; wr_valid twice with 0xA5, 0x3C; stop_det once.
REQ-035 Write 0x86 (addr 0x43) -> sda_oe never asserts; no wr_valid; busy stays 0.
REQ-036 Read 0x85, rd_data 0x5A then 0xC3, controller ACK then NACK -> SDA bits 0x5A, 0xC3; rd_req twice; sda_oe=0 after NACK.
REQ-037 Write 0x84, data 0x11, repeated START, 0x85, read one byte NACK -> wr_valid 0x11, start_det twice, then correct read.
REQ-038 rst pulse mid-bit 4 of write data -> sda_oe=0, IDLE next cycle; remaining bits ignored; next START+0x84 ACKed.
REQ-039 STOP in middle of READ byte -> sda_oe=0 next cycle, busy=0, no further rd_req.
